// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one single-port unified memory between
// instruction fetch and load/store, one access in flight at a time.
module mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LAT_CNT    = 3'(LAT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       own;
    logic       own_nx;
    logic       is_we;
    logic       is_we_nx;
    logic       is_err;
    logic       is_err_nx;
    logic [2:0] starve;
    logic [2:0] starve_nx;

    logic       idle;
    logic       force_f;
    logic       misalign;
    logic       win_d;
    logic       win_f;
    logic       done;

    // Fetch never checks alignment; the byte offset is simply dropped.
    logic       unused_if_lsb;
    assign unused_if_lsb = &{1'b0, if_addr[1:0]};

    // Arbitration: data wins ties unless fetch has starved long enough
    always_comb begin
        idle     = (state == IDLE);
        force_f  = (starve == STARVE_LIM);
        misalign = (d_addr[1:0] != 2'b00);
        win_d    = idle & d_req & ~(if_req & force_f);
        win_f    = idle & if_req & ~win_d;
        done     = (state == BUSY) & (cnt == 3'd1);
    end

    // State register plus per-access bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            own    <= 1'b0;
            is_we  <= 1'b0;
            is_err <= 1'b0;
            starve <= 3'd0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            own    <= own_nx;
            is_we  <= is_we_nx;
            is_err <= is_err_nx;
            starve <= starve_nx;
        end
    end

    // Next state: grant launches an access, latency countdown ends it
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        own_nx    = own;
        is_we_nx  = is_we;
        is_err_nx = is_err;
        case (state)
            IDLE: begin
                if (win_d | win_f) begin
                    state_nx  = BUSY;
                    own_nx    = win_d;
                    is_we_nx  = win_d & d_we;
                    is_err_nx = win_d & misalign;
                    cnt_nx    = (win_d & misalign) ? 3'd1 : LAT_CNT;
                end
            end
            BUSY: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Starvation count: lost arbitrations while fetch keeps asking
    always_comb begin
        starve_nx = starve;
        if (!if_req || win_f) begin
            starve_nx = 3'd0;
        end else if (win_d && (starve < STARVE_LIM)) begin
            starve_nx = starve + 3'd1;
        end
    end

    // Outputs: grants, memory strobe, completions and pc stall
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 30'd0;
        mem_wdata = 32'd0;
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'd0;
        d_err     = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            if_gnt = win_f;
            d_gnt  = win_d;
            mem_en = win_f | (win_d & ~misalign);
            if (mem_en) begin
                mem_addr  = win_f ? if_addr[31:2] : d_addr[31:2];
                mem_we    = win_d & d_we;
                mem_wdata = d_wdata;
            end
            if_rvalid = done & ~own;
            d_rvalid  = done & own;
            if (if_rvalid) begin
                if_rdata = mem_rdata;
            end
            if (d_rvalid) begin
                d_err = is_err;
                if (!is_we && !is_err) begin
                    d_rdata = mem_rdata;
                end
            end
            stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: four arbiters (LAT 1..4) with memory models, directed
// scenarios and randomized traffic checked against a cycle-level model.
module tb_mem_arbiter;

    localparam int SMAX = 3;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h2009_0005;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input int lat,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL lat%0d %s: got %h expected %h", lat, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int L = g + 1;

        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        d_err;
        logic        mem_en;
        logic        mem_we;
        logic [29:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        stall;
        logic        fin = 1'b0;

        mem_arbiter #(.LAT(L), .STARVE_MAX(SMAX)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
            .d_err(d_err),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
            .stall(stall)
        );

        // Memory: data appears exactly L cycles after the strobe, junk otherwise
        logic [31:0] mem  [0:255];
        logic [31:0] pipe [0:3];
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            end else if (mem_en && mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
            end
            pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : $urandom;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata = pipe[L-1];

        // Reference model: transaction view with absolute completion cycle
        logic [31:0] shadow [0:255];
        int          m_cyc = 0;
        int          m_done_at = 0;
        int          m_st = 0;
        bit          m_busy = 0;
        bit          m_owner = 0;
        bit          m_err = 0;
        bit          m_if_rv = 0;
        bit          m_d_rv = 0;
        logic [31:0] m_res;
        bit          fw, dw, mis;
        bit          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err;
        bit          e_mem_en, e_mem_we, e_stall;
        logic [29:0] e_mem_addr;
        logic [31:0] e_mem_wdata;

        always @(negedge clk) begin
            e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0;
            e_mem_en = 0; e_mem_we = 0; e_stall = 0;
            e_mem_addr = '0; e_mem_wdata = '0;
            fw = 0; dw = 0; mis = 0;
            if (rst) begin
                m_busy = 0;
                m_st = 0;
                for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
            end else begin
                if (!m_busy) begin
                    fw = if_req && (!d_req || m_st == SMAX);
                    dw = d_req && !fw;
                    if (fw || dw) begin
                        mis = dw && (d_addr[1:0] != 2'b00);
                        e_if_gnt = fw;
                        e_d_gnt = dw;
                        e_mem_en = !mis;
                        e_mem_addr = fw ? if_addr[31:2] : d_addr[31:2];
                        e_mem_we = dw && d_we && !mis;
                        e_mem_wdata = d_wdata;
                        m_busy = 1;
                        m_owner = dw;
                        m_err = mis;
                        m_done_at = m_cyc + (mis ? 1 : L);
                        if (fw) m_res = shadow[if_addr[9:2]];
                        else if (mis || d_we) m_res = 32'd0;
                        else m_res = shadow[d_addr[9:2]];
                        if (e_mem_we) shadow[d_addr[9:2]] = d_wdata;
                    end
                end else if (m_cyc == m_done_at) begin
                    e_if_rv = !m_owner;
                    e_d_rv = m_owner;
                    e_err = m_owner && m_err;
                    m_busy = 0;
                end
                e_stall = (if_req && !e_if_rv) || (d_req && !e_d_rv);
                if (!if_req || fw) m_st = 0;
                else if (dw && m_st < SMAX) m_st++;
            end
            m_if_rv = e_if_rv;
            m_d_rv = e_d_rv;
            m_cyc++;
            chk("m_if_gnt", L, if_gnt, e_if_gnt);
            chk("m_d_gnt", L, d_gnt, e_d_gnt);
            chk("m_if_rvalid", L, if_rvalid, e_if_rv);
            chk("m_d_rvalid", L, d_rvalid, e_d_rv);
            chk("m_d_err", L, d_err, e_err);
            chk("m_mem_en", L, mem_en, e_mem_en);
            chk("m_stall", L, stall, e_stall);
            if (e_if_rv) chk("m_if_rdata", L, if_rdata, m_res);
            if (e_d_rv) chk("m_d_rdata", L, d_rdata, m_res);
            if (e_mem_en) begin
                chk("m_mem_addr", L, mem_addr, e_mem_addr);
                chk("m_mem_we", L, mem_we, e_mem_we);
            end
            if (e_mem_we) chk("m_mem_wdata", L, mem_wdata, e_mem_wdata);
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        // Directed scenarios, then randomized requesters obeying hold rules
        initial begin
            rst = 1; if_req = 1; if_addr = 0;
            d_req = 1; d_we = 0; d_addr = 0; d_wdata = 0;
            @(posedge clk);
            step();
            @(negedge clk);
            chk("rst_if_gnt", L, if_gnt, 0);
            chk("rst_d_gnt", L, d_gnt, 0);
            chk("rst_mem_en", L, mem_en, 0);
            chk("rst_stall", L, stall, 0);
            step(); rst = 0; if_req = 0; d_req = 0;
            step();

            if_req = 1; if_addr = 32'h0000_0010;
            @(negedge clk);
            chk("fetch_gnt", L, if_gnt, 1);
            chk("fetch_mem_en", L, mem_en, 1);
            chk("fetch_mem_addr", L, mem_addr, 4);
            repeat (L) step();
            @(negedge clk);
            chk("fetch_rvalid", L, if_rvalid, 1);
            chk("fetch_rdata", L, if_rdata, 32'h2009_0005);
            chk("fetch_stall", L, stall, 0);
            step(); if_req = 0;
            step();

            d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("st_gnt", L, d_gnt, 1);
            chk("st_mem_we", L, mem_we, 1);
            chk("st_mem_addr", L, mem_addr, 32'h10);
            repeat (L) step();
            @(negedge clk);
            chk("st_rvalid", L, d_rvalid, 1);
            chk("st_rdata", L, d_rdata, 0);
            step(); d_we = 0;
            @(negedge clk);
            chk("ld_gnt", L, d_gnt, 1);
            chk("ld_mem_we", L, mem_we, 0);
            repeat (L) step();
            @(negedge clk);
            chk("ld_rvalid", L, d_rvalid, 1);
            chk("ld_rdata", L, d_rdata, 32'hDEAD_BEEF);
            step(); d_req = 0;
            step();

            if_req = 1; if_addr = 0; d_req = 1; d_we = 0; d_addr = 32'h80;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("arb_d_gnt", L, d_gnt, (k % 4) != 3);
                chk("arb_if_gnt", L, if_gnt, (k % 4) == 3);
                repeat (L + 1) step();
            end
            if_req = 0; d_req = 0;
            step();

            d_req = 1; d_we = 0; d_addr = 32'h0000_0006;
            @(negedge clk);
            chk("mis_gnt", L, d_gnt, 1);
            chk("mis_mem_en", L, mem_en, 0);
            step();
            @(negedge clk);
            chk("mis_rvalid", L, d_rvalid, 1);
            chk("mis_err", L, d_err, 1);
            chk("mis_rdata", L, d_rdata, 0);
            step(); d_req = 0;
            step();

            if_req = 1; if_addr = 32'h10;
            @(negedge clk);
            chk("rmid_gnt", L, if_gnt, 1);
            repeat ((L > 2) ? 2 : 1) step();
            rst = 1;
            @(negedge clk);
            chk("rmid_rvalid", L, if_rvalid, 0);
            chk("rmid_stall", L, stall, 0);
            chk("rmid_mem_en", L, mem_en, 0);
            step(); rst = 0;
            @(negedge clk);
            chk("rmid_regnt", L, if_gnt, 1);
            chk("rmid_reen", L, mem_en, 1);
            repeat (L) step();
            @(negedge clk);
            chk("rmid_rdata", L, if_rdata, 32'h2009_0005);
            step(); if_req = 0;
            step();

            if_req = 1; if_addr = 32'h20;
            @(negedge clk);
            chk("drop_gnt", L, if_gnt, 1);
            step(); if_req = 0;
            repeat (L - 1) step();
            @(negedge clk);
            chk("drop_rvalid", L, if_rvalid, 1);
            chk("drop_no_gnt", L, if_gnt, 0);
            step(); if_req = 1; if_addr = 32'h24;
            @(negedge clk);
            chk("drop_regnt", L, if_gnt, 1);
            repeat (L) step();
            step(); if_req = 0;
            step();

            for (int c = 0; c < 3000; c++) begin
                if (if_req) begin
                    if (m_if_rv) begin
                        if ($urandom_range(0, 9) < 6) if_addr = $urandom;
                        else if_req = 0;
                    end else if (m_busy && !m_owner &&
                                 $urandom_range(0, 19) == 0) begin
                        if_req = 0;
                    end
                end else if (!(m_busy && !m_owner) &&
                             $urandom_range(0, 1) == 1) begin
                    if_req = 1;
                    if_addr = $urandom;
                end
                if (d_req) begin
                    if (m_d_rv) begin
                        if ($urandom_range(0, 9) < 6) begin
                            d_addr = {$urandom, 2'b00};
                            if ($urandom_range(0, 6) == 0)
                                d_addr[1:0] = 2'($urandom_range(1, 3));
                            d_we = ($urandom_range(0, 4) < 2);
                            d_wdata = $urandom;
                        end else begin
                            d_req = 0;
                        end
                    end else if (m_busy && m_owner &&
                                 $urandom_range(0, 19) == 0) begin
                        d_req = 0;
                    end
                end else if (!(m_busy && m_owner) &&
                             $urandom_range(0, 2) != 0) begin
                    d_req = 1;
                    d_addr = {$urandom, 2'b00};
                    if ($urandom_range(0, 6) == 0)
                        d_addr[1:0] = 2'($urandom_range(1, 3));
                    d_we = ($urandom_range(0, 4) < 2);
                    d_wdata = $urandom;
                end
                step();
            end
            if_req = 0; d_req = 0;
            repeat (8) step();
            fin = 1;
        end
    end

    initial begin
        bit all_done;
        all_done = 0;
        for (int c = 0; c < 60000 && !all_done; c++) begin
            @(posedge clk);
            all_done = lane[0].fin && lane[1].fin &&
                       lane[2].fin && lane[3].fin;
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL timeout: lanes done %0b, required 1", all_done);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares one single-port unified memory between the processor's instruction-fetch path and its load/store path. It replaces the separate instruction and data memories on the memory side and produces the `stall` that freezes the `pc` register while an access is outstanding. Only one access is in flight at a time. Data accesses win ties, and a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- `LAT`, 1: memory read/write latency in cycles; legal range 1–4.
- `STARVE_MAX`, 3: consecutive lost arbitrations after which a pending fetch is forced to win; legal range 1–7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch complete; `if_rdata` valid.
- `if_rdata` out 32: instruction word.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: data access complete; `d_rdata`/`d_err` valid.
- `d_rdata` out 32: load data; 0 for stores and errors.
- `d_err` out 1: misaligned data address.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 30: word address (byte address [31:2]).
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid exactly `LAT` cycles after the `mem_en` cycle.
- `stall` out 1: `(if_req & ~if_rvalid) | (d_req & ~d_rvalid)`.

## Operation
- **States:** IDLE and BUSY. A 3-bit latency counter `cnt`, an owner flag `own` (0 = fetch, 1 = data), and a 3-bit starvation counter `starve`.
- **Reset values:** IDLE, `cnt` = 0, `own` = 0, `starve` = 0. All outputs are 0 while `rst` is high.
- **IDLE arbitration (combinational, same cycle):**
  - Only `d_req`: data wins.
  - Only `if_req`: fetch wins.
  - Both: data wins unless `starve == STARVE_MAX`, in which case fetch wins.
  - The winner's `gnt` is 1. `mem_en` = 1, `mem_addr` = winner addr[31:2], `mem_we` = `d_we & (winner is data)`, `mem_wdata` = `d_wdata`.
- **Grant register update:** on a grant, the next state is BUSY, `cnt` loads `LAT`, and `own` records the winner.
- **Starvation counter:**
  - Increments (saturating at `STARVE_MAX`) when data wins while `if_req` = 1.
  - Clears when fetch wins or when `if_req` = 0.
- **Misaligned data (`d_addr[1:0] != 0`) on a data grant:** `mem_en` = 0. Next state is BUSY with `cnt` = 1; completion reports `d_err` = 1 and `d_rdata` = 0. Fetch addresses are not checked; bits [1:0] are dropped.
- **BUSY:**
  - `cnt` decrements each cycle.
  - In the cycle where `cnt == 1`: the owner's `rvalid` = 1, and `rdata` = `mem_rdata` (fetch, or data load) or 0 (store, or error). Next state is IDLE.
  - No grants are issued, and `mem_en` = 0 throughout BUSY.
- **Requester rules:** hold `req`, address, `we` and `wdata` stable from assertion through the `rvalid` cycle. `req` high in IDLE after a completion is a new request. Dropping `req` before `rvalid` has no effect on the in-flight access; the response is still issued.
- **Reset mid-access:** the access is abandoned, no `rvalid` is produced, and the state returns to IDLE. Memory-side completion of an already-strobed write is not the arbiter's concern.

## Timing
- Grant at cycle T (IDLE). `rvalid` at T+`LAT`. Earliest next grant at T+`LAT`+1.
- Throughput is one access per `LAT`+1 cycles.
- Misaligned data: grant at T, `rvalid` with `d_err` at T+1.
- `gnt`, `mem_*`, `rvalid`, `rdata` and `stall` are combinational from the registered state and the inputs.
- No combinational path exists from `mem_rdata` to any `gnt`.
- `stall` falls in the `rvalid` cycle of the last outstanding request, so `pc` updates on that edge.

## Test plan
- **Isolated fetch:** `LAT` = 1, `if_req` only, addr 0x0000_0010, memory word 4 = 0x2009_0005.
  - Required: `if_gnt` and `mem_en` at T with `mem_addr` = 4.
  - Required: `if_rvalid` at T+1 with `if_rdata` = 0x2009_0005, and `stall` = 0 at T+1.
- **Store then load:** `LAT` = 3. Store 0xDEAD_BEEF to 0x40, then load 0x40.
  - Required: store `rvalid` at T+3 with `d_rdata` = 0; load granted at T+4; load `rvalid` at T+7 with 0xDEAD_BEEF.
- **Simultaneous requests:** `LAT` = 1, `STARVE_MAX` = 3, both `if_req` and `d_req` held continuously.
  - Required grant order: D, D, D, F, D, D, D, F.
  - Required: `starve` reads 0, 1, 2, 3, 0 across those grants.
- **Misaligned load:** `d_addr` = 0x0000_0006.
  - Required: `d_gnt` with `mem_en` = 0; next cycle `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0.
- **Reset mid-access:** `LAT` = 4, assert `rst` at T+2 of a fetch.
  - Required: all outputs 0 immediately, no `if_rvalid`, and a new grant in the first cycle after `rst` falls.
- **Early request drop:** `if_req` dropped at T+1 with `LAT` = 2.
  - Required: `if_rvalid` still at T+2, and no grant until T+3.
